// File: rtl/onebit_mixer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onebit_mixer_mc: NCH-channel 1-bit RF mixer with RF stuck detection   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module onebit_mixer_mc #(
  parameter int W             = 12,
  parameter int NCH           = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STUCK_LIMIT   = 4096,
  parameter bit MUTE_ON_STUCK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rf_in,
  input  logic [NCH*W-1:0]   lo_sin,
  input  logic [NCH*W-1:0]   lo_cos,
  input  logic               lo_valid,
  input  logic               en,
  input  logic               polarity,
  output logic               rf_out,
  output logic [NCH*W-1:0]   mix_sin,
  output logic [NCH*W-1:0]   mix_cos,
  output logic               mix_valid,
  output logic               rf_stuck
);

  localparam int                 c_cnt_w  = $clog2(STUCK_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_lim    = c_cnt_w'(STUCK_LIMIT);
  localparam logic [c_cnt_w-1:0] c_lim_m2 = c_cnt_w'(STUCK_LIMIT - 2);
  localparam logic [W-1:0]       c_min    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]       c_max    = {1'b0, {(W-1){1'b1}}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rf_prev;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_stuck;
  logic [NCH*W-1:0]       r_mix_sin;
  logic [NCH*W-1:0]       r_mix_cos;
  logic                   r_valid;

  logic                   w_rf_s;
  logic                   w_neg;
  logic                   w_mute;
  logic [NCH*W-1:0]       w_mix_sin;
  logic [NCH*W-1:0]       w_mix_cos;

  // Negating the most negative code would wrap, so clamp it to the max.
  function automatic logic [W-1:0] f_mix(input logic [W-1:0] x, input logic neg);
    if (!neg)
      return x;
    else if (x == c_min)
      return c_max;
    else
      return -x;
  endfunction

  assign w_rf_s = r_sync[SYNC_STAGES-1];
  assign w_neg  = w_rf_s ^ polarity;
  assign w_mute = MUTE_ON_STUCK && r_stuck;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign w_mix_sin[k*W +: W] = f_mix(lo_sin[k*W +: W], w_neg);
    assign w_mix_cos[k*W +: W] = f_mix(lo_cos[k*W +: W], w_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '1;
      r_rf_prev <= 1'b1;
      r_cnt     <= '0;
      r_stuck   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rf_in};
      r_rf_prev <= w_rf_s;
      if (w_rf_s != r_rf_prev) begin
        r_cnt   <= '0;
        r_stuck <= 1'b0;
      end else begin
        if (r_cnt != c_lim)
          r_cnt <= r_cnt + 1'b1;
        // Flag lands on the edge where the count becomes STUCK_LIMIT-1.
        if (r_cnt == c_lim_m2)
          r_stuck <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mix_sin <= '0;
      r_mix_cos <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= lo_valid & en;
      if (!en || w_mute) begin
        r_mix_sin <= '0;
        r_mix_cos <= '0;
      end else if (lo_valid) begin
        r_mix_sin <= w_mix_sin;
        r_mix_cos <= w_mix_cos;
      end
    end
  end

  assign rf_out    = r_sync[0];
  assign mix_sin   = r_mix_sin;
  assign mix_cos   = r_mix_cos;
  assign mix_valid = r_valid;
  assign rf_stuck  = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_onebit_mixer_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_onebit_mixer_mc: randomised bench with behavioural mixer model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_onebit_mixer_mc;

  localparam int W           = 12;
  localparam int NCH         = 2;
  localparam int SYNC_STAGES = 2;
  localparam int STUCK_LIMIT = 16;
  localparam bit MUTE        = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rf_in = 1'b0;
  logic [NCH*W-1:0] lo_sin = '0;
  logic [NCH*W-1:0] lo_cos = '0;
  logic             lo_valid = 1'b0;
  logic             en = 1'b0;
  logic             polarity = 1'b0;
  logic             rf_out;
  logic [NCH*W-1:0] mix_sin;
  logic [NCH*W-1:0] mix_cos;
  logic             mix_valid;
  logic             rf_stuck;

  int n_cmp = 0;
  int n_bad = 0;

  onebit_mixer_mc #(
    .W(W), .NCH(NCH), .SYNC_STAGES(SYNC_STAGES),
    .STUCK_LIMIT(STUCK_LIMIT), .MUTE_ON_STUCK(MUTE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rf_in(rf_in),
    .lo_sin(lo_sin), .lo_cos(lo_cos), .lo_valid(lo_valid),
    .en(en), .polarity(polarity), .rf_out(rf_out),
    .mix_sin(mix_sin), .mix_cos(mix_cos), .mix_valid(mix_valid),
    .rf_stuck(rf_stuck)
  );

  always #5 clk = ~clk;

  // Reference model: rf_s is rf_in delayed SYNC_STAGES samples; the stuck
  // flag is "run of unchanged rf_s samples has reached STUCK_LIMIT-1".
  bit q[$];
  bit m_prev;
  int m_run;
  int m_sin[NCH];
  int m_cos[NCH];
  bit m_valid;

  function automatic int mixv(input logic [W-1:0] x, input bit neg);
    int v;
    v = int'($signed(x));
    if (neg) v = -v;
    if (v > (1 << (W-1)) - 1) v = (1 << (W-1)) - 1;
    return v;
  endfunction

  function automatic bit m_stuck();
    return (m_run >= STUCK_LIMIT - 1);
  endfunction

  function automatic int sget(input logic [NCH*W-1:0] v, input int k);
    logic signed [W-1:0] a;
    a = v[k*W +: W];
    return int'(a);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) q.push_back(1'b1);
    m_prev  = 1'b1;
    m_run   = 0;
    m_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_sin[k] = 0;
      m_cos[k] = 0;
    end
  endtask

  task automatic model_step();
    bit rs, neg, stuck_pre;
    rs        = q[0];
    neg       = rs ^ polarity;
    stuck_pre = m_stuck();
    m_valid   = lo_valid & en;
    for (int k = 0; k < NCH; k++) begin
      if (!en || (MUTE && stuck_pre)) begin
        m_sin[k] = 0;
        m_cos[k] = 0;
      end else if (lo_valid) begin
        m_sin[k] = mixv(lo_sin[k*W +: W], neg);
        m_cos[k] = mixv(lo_cos[k*W +: W], neg);
      end
    end
    if (rs != m_prev) m_run = 0;
    else if (m_run < STUCK_LIMIT) m_run++;
    m_prev = rs;
    void'(q.pop_front());
    q.push_back(rf_in);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NCH; k++) begin
          cmp($sformatf("model mix_sin[%0d]", k), sget(mix_sin, k), m_sin[k]);
          cmp($sformatf("model mix_cos[%0d]", k), sget(mix_cos, k), m_cos[k]);
        end
        cmp("model mix_valid", int'(mix_valid), int'(m_valid));
        cmp("model rf_stuck", int'(rf_stuck), int'(m_stuck()));
        cmp("model rf_out", int'(rf_out), int'(q[$]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_lo(input int s0, input int s1, input int c0, input int c1);
    lo_sin = {W'(s1), W'(s0)};
    lo_cos = {W'(c1), W'(c0)};
  endtask

  task automatic rand_segments(input int nseg);
    int len;
    logic [W-1:0] v;
    for (int seg = 0; seg < nseg; seg++) begin
      len   = (seg % 5 == 4) ? $urandom_range(18, 30) : $urandom_range(1, 8);
      rf_in = ~rf_in;
      for (int c = 0; c < len; c++) begin
        lo_valid = ($urandom_range(0, 3) != 0);
        en       = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) polarity = ~polarity;
        for (int k = 0; k < NCH; k++) begin
          v = W'($urandom_range(0, (1 << W) - 1));
          if ($urandom_range(0, 7) == 0) v = {1'b1, {(W-1){1'b0}}};
          lo_sin[k*W +: W] = v;
          v = W'($urandom_range(0, (1 << W) - 1));
          if ($urandom_range(0, 7) == 0) v = {1'b1, {(W-1){1'b0}}};
          lo_cos[k*W +: W] = v;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    cmp("reset mix_valid", int'(mix_valid), 0);
    cmp("reset mix_sin0", sget(mix_sin, 0), 0);
    cmp("reset mix_cos1", sget(mix_cos, 1), 0);
    cmp("reset rf_stuck", int'(rf_stuck), 0);
    cmp("reset rf_out", int'(rf_out), 1);

    rst_n = 1'b1; rf_in = 1'b0; polarity = 1'b0; en = 1'b1; lo_valid = 1'b1;
    set_lo(100, -5, 7, -7);
    repeat (5) @(negedge clk);
    cmp("pos sin0", sget(mix_sin, 0), 100);
    cmp("pos sin1", sget(mix_sin, 1), -5);
    cmp("pos cos0", sget(mix_cos, 0), 7);
    cmp("pos valid", int'(mix_valid), 1);

    rf_in = 1'b1;
    repeat (4) @(negedge clk);
    cmp("neg sin0", sget(mix_sin, 0), -100);
    cmp("neg sin1", sget(mix_sin, 1), 5);
    cmp("neg cos1", sget(mix_cos, 1), 7);
    polarity = 1'b1;
    @(negedge clk);
    cmp("pol sin0", sget(mix_sin, 0), 100);
    cmp("pol sin1", sget(mix_sin, 1), -5);
    polarity = 1'b0;
    set_lo(100, -5, -2048, 2047);
    @(negedge clk);
    cmp("sat cos0", sget(mix_cos, 0), 2047);
    cmp("sat cos1", sget(mix_cos, 1), -2047);

    // Edge latency: rf_out after 1 cycle, product sign after SYNC_STAGES+1.
    rf_in = 1'b0;
    set_lo(300, 300, 300, 300);
    repeat (4) @(negedge clk);
    rf_in = 1'b1;
    @(negedge clk);
    cmp("edge rf_out t+1", int'(rf_out), 1);
    cmp("edge sin0 t+1", sget(mix_sin, 0), 300);
    @(negedge clk);
    cmp("edge sin0 t+2", sget(mix_sin, 0), 300);
    @(negedge clk);
    cmp("edge sin0 t+3", sget(mix_sin, 0), -300);

    k = 3;
    while (!rf_stuck && k < 100) begin
      @(negedge clk);
      k++;
    end
    cmp("stuck latency", k, SYNC_STAGES + STUCK_LIMIT);
    cmp("stuck first cycle sin0", sget(mix_sin, 0), -300);
    @(negedge clk);
    cmp("mute sin0", sget(mix_sin, 0), 0);
    cmp("mute cos1", sget(mix_cos, 1), 0);
    cmp("mute valid", int'(mix_valid), 1);
    cmp("mute stuck", int'(rf_stuck), 1);

    rf_in = 1'b0;
    repeat (2) @(negedge clk);
    cmp("unstick hold", int'(rf_stuck), 1);
    @(negedge clk);
    cmp("unstick clear", int'(rf_stuck), 0);
    cmp("unstick still muted", sget(mix_sin, 0), 0);
    @(negedge clk);
    cmp("unstick resume", sget(mix_sin, 0), 300);

    en = 1'b0;
    lo_valid = 1'b1;
    @(negedge clk);
    cmp("en0 valid", int'(mix_valid), 0);
    cmp("en0 sin0", sget(mix_sin, 0), 0);
    cmp("en0 cos0", sget(mix_cos, 0), 0);
    en = 1'b1;

    rand_segments(50);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async rst valid", int'(mix_valid), 0);
    cmp("async rst sin1", sget(mix_sin, 1), 0);
    cmp("async rst cos0", sget(mix_cos, 0), 0);
    cmp("async rst stuck", int'(rf_stuck), 0);
    cmp("async rst rf_out", int'(rf_out), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rand_segments(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onebit_mixer_mc.md
Name: onebit_mixer_mc

Overview:
- Parametrised successor to the single-channel 1-bit RF mixer.
- Synchronises the 1-bit comparator RF stream through a configurable-depth register chain, then multiplies it (±1) by NCH channels of NCO sine/cosine samples of width W. Negation is saturating.
- Adds polarity control, enable/valid handshake, and an RF stuck-input detector with optional output muting.
- Sits between the NCO bank and the CIC decimators.

Parameters:
- W, 12, LO and mixer-output sample width (signed two's complement).
- NCH, 1, number of independent LO channels sharing one RF bit.
- SYNC_STAGES, 2, RF synchroniser depth (≥2).
- STUCK_LIMIT, 4096, consecutive cycles without an RF transition before rf_stuck asserts (≥2).
- MUTE_ON_STUCK, 1, when 1 the mixer outputs are forced to 0 while rf_stuck=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rf_in  in  1  asynchronous 1-bit RF from LVDS comparator.
- lo_sin  in  NCH*W  packed signed sine samples; channel k at bits [k*W +: W].
- lo_cos  in  NCH*W  packed signed cosine samples, same packing.
- lo_valid  in  1  LO samples valid this cycle.
- en  in  1  mixer enable.
- polarity  in  1  0: rf=0 → +LO, rf=1 → −LO; 1: inverted.
- rf_out  out  1  first synchroniser stage, fed back to the comparator feedback pin.
- mix_sin  out  NCH*W  mixed sine products, same packing.
- mix_cos  out  NCH*W  mixed cosine products, same packing.
- mix_valid  out  1  mix_sin/mix_cos valid.
- rf_stuck  out  1  no RF transition for STUCK_LIMIT cycles.

Behaviour:
- Reset (async assert, sync release by clk):
  - All synchroniser stages = 1.
  - mix_sin = mix_cos = 0; mix_valid = 0.
  - rf_stuck = 0; stuck counter = 0.
- Synchroniser:
  - sync[0] <= rf_in; sync[i] <= sync[i-1] each cycle.
  - rf_out = sync[0].
  - rf_s = sync[SYNC_STAGES-1].
- Sign select: neg = rf_s XOR polarity.
- Mix (per channel, sine and cosine independently, one registered stage):
  - neg=0: out <= lo.
  - neg=1: out <= −lo, saturating: −(−2^(W−1)) yields 2^(W−1)−1. No other value saturates.
- Latency: LO sample presented at cycle n appears on the outputs at n+1, combined with rf_s as sampled at cycle n. An rf_in edge affects outputs SYNC_STAGES+1 cycles later.
- Handshake:
  - mix_valid <= lo_valid & en.
  - When lo_valid=0 and en=1, outputs hold their previous values.
  - en=0: outputs <= 0 and mix_valid <= 0 on the next cycle. The synchroniser and stuck detector keep running.
- Stuck detector:
  - rf_prev <= rf_s.
  - If rf_s ≠ rf_prev: counter <= 0 and rf_stuck <= 0.
  - Otherwise the counter increments, saturating at STUCK_LIMIT. rf_stuck <= 1 when the counter reaches STUCK_LIMIT−1 (flag asserted exactly STUCK_LIMIT cycles after the last transition).
  - rf_prev resets to 1.
- Mute:
  - MUTE_ON_STUCK=1 and rf_stuck=1: outputs <= 0. mix_valid still follows lo_valid & en, so downstream filters keep their rate.
  - Priority: reset > en=0 > mute > mix.
- Transition clears rf_stuck on the same edge the counter clears. Muting ends on the following output update.
- Reset mid-operation clears all state immediately. The first valid output after release requires lo_valid & en at least one cycle after release.

Test Plan:
- W=12, NCH=2, polarity=0, hold rf_in=0 ≥4 cycles, lo_sin ch0=100, ch1=−5, lo_valid=en=1 → next cycle mix_sin ch0=100, ch1=−5, mix_valid=1.
- Same, rf_in=1 → ch0=−100, ch1=5; set polarity=1 → ch0=100, ch1=−5.
- rf_in=1, lo_cos=−2048 → mix_cos=2047 (saturation); lo_cos=2047 → mix_cos=−2047.
- Toggle rf_in once at cycle t (SYNC_STAGES=2), constant LO=300 → output sign flips at cycle t+3, not before; rf_out changes at t+1.
- STUCK_LIMIT=16, rf_in constant after last edge → rf_stuck=1 exactly 16 cycles after rf_s transition; outputs 0 while mix_valid=1. Next rf_in edge → rf_stuck=0, outputs resume.
- Assert rst_n=0 mid-stream → all outputs 0 asynchronously. en=0 with lo_valid=1 → mix_valid=0, outputs 0.
